// File: rtl/mc_dp_pkg.sv
// Shared sequencer states, ALU opcodes and register constants for the multi-cycle datapath.
// No logic, so no latency.
// No flow control of its own.
package mc_dp_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam int ALU_AND = 0;
    localparam int ALU_OR  = 1;
    localparam int ALU_ADD = 2;
    localparam int ALU_SLL = 3;
    localparam int ALU_SRL = 4;
    localparam int ALU_SUB = 6;
    localparam int ALU_SLT = 7;
    localparam int ALU_NOR = 12;

    localparam logic [4:0] REG_RA = 5'd31;

endpackage

// File: rtl/mc_dp_sequencer.sv
// Instruction sequencer: FETCH/DECODE/EXEC/MEM/WB/HALT state machine with request holding and retire decode.
// Request and retire outputs are decoded from the current state and handshakes in the same cycle.
// Memory requests stay asserted until the matching ready; only reset withdraws them.
module mc_dp_sequencer
    import mc_dp_pkg::*;
(
    input  logic   i_clk,
    input  logic   i_rst_b,
    input  logic   i_halted,
    input  logic   i_imem_ready,
    input  logic   i_dmem_ready,
    input  logic   i_mem_read,
    input  logic   i_mem_write,
    input  logic   i_reg_write_enable,
    output state_t o_state,
    output logic   o_imem_req,
    output logic   o_dmem_req,
    output logic   o_fetch_done,
    output logic   o_mem_done,
    output logic   o_retire
);

    state_t r_state;
    logic   r_fetch_busy;
    logic   w_mem_op;
    logic   w_load_wb;

    assign w_mem_op  = i_mem_read | i_mem_write;
    assign w_load_wb = i_mem_read & i_reg_write_enable;

    // halted only counts on the first FETCH cycle; once a request is out it is held to completion
    assign o_imem_req   = i_rst_b & (r_state == FETCH) & (r_fetch_busy | ~i_halted);
    assign o_dmem_req   = i_rst_b & (r_state == MEM);
    assign o_fetch_done = o_imem_req & i_imem_ready;
    assign o_mem_done   = o_dmem_req & i_dmem_ready;
    assign o_retire     = i_rst_b & ((r_state == WB)
                                   | ((r_state == EXEC) & ~w_mem_op & ~i_reg_write_enable)
                                   | (o_mem_done & ~w_load_wb));
    assign o_state      = r_state;

    always_ff @(posedge i_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            r_state      <= FETCH;
            r_fetch_busy <= 1'b0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (!r_fetch_busy && i_halted) begin
                        r_state <= HALT;
                    end else if (o_fetch_done) begin
                        r_state      <= DECODE;
                        r_fetch_busy <= 1'b0;
                    end else begin
                        r_fetch_busy <= 1'b1;
                    end
                end
                DECODE: r_state <= EXEC;
                EXEC: begin
                    if (w_mem_op)                r_state <= MEM;
                    else if (i_reg_write_enable) r_state <= WB;
                    else                         r_state <= FETCH;
                end
                MEM: begin
                    if (o_mem_done) r_state <= w_load_wb ? WB : FETCH;
                end
                WB:      r_state <= FETCH;
                HALT:    r_state <= HALT;
                default: r_state <= FETCH;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_data_path.sv
// Multi-cycle MIPS datapath: PC/IR/A/B/ALUOut/MDR registers, register file and ALU around the sequencer.
// Zero-wait latency: ALU op 4, load 5, store 4, branch/jump 3 cycles; each memory wait adds one.
// imem/dmem requests hold address and data stable until ready.
module multicycle_data_path
    import mc_dp_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter int               ALU_OP_W = 4
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic                halted,
    output logic [XLEN-1:0]     inst,
    output logic [XLEN-1:0]     inst_addr,
    output logic                imem_req,
    output logic [XLEN-1:0]     imem_addr,
    input  logic [XLEN-1:0]     imem_rdata,
    input  logic                imem_ready,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [XLEN-1:0]     dmem_addr,
    output logic [XLEN-1:0]     dmem_wdata,
    input  logic [XLEN-1:0]     dmem_rdata,
    input  logic                dmem_ready,
    input  logic                reg_dest,
    input  logic                alu_src,
    input  logic                mem_or_reg,
    input  logic                reg_or_mem,
    input  logic                link,
    input  logic                branch,
    input  logic                branch_ne,
    input  logic                jump,
    input  logic                jump_register,
    input  logic                does_shift_amount_need,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic                reg_write_enable,
    input  logic [ALU_OP_W-1:0] alu_operation,
    output logic                retire,
    output logic                misaligned,
    output logic [2:0]          state
);

    function automatic logic [XLEN-1:0] alu_f(input logic [ALU_OP_W-1:0] op,
                                              input logic [XLEN-1:0]     a,
                                              input logic [XLEN-1:0]     b);
        logic [XLEN-1:0] y;
        case (op)
            ALU_OP_W'(ALU_AND): y = a & b;
            ALU_OP_W'(ALU_OR):  y = a | b;
            ALU_OP_W'(ALU_ADD): y = a + b;
            ALU_OP_W'(ALU_SLL): y = a << b[4:0];
            ALU_OP_W'(ALU_SRL): y = a >> b[4:0];
            ALU_OP_W'(ALU_SUB): y = a - b;
            ALU_OP_W'(ALU_SLT): y = ($signed(a) < $signed(b)) ? XLEN'(1) : '0;
            ALU_OP_W'(ALU_NOR): y = ~(a | b);
            default:            y = '0;
        endcase
        return y;
    endfunction

    state_t          w_state;
    logic            w_fetch_done, w_mem_done;
    logic [XLEN-1:0] r_pc, r_ir, r_inst_addr, r_a, r_b, r_alu_out, r_mdr;
    logic            r_misaligned;
    logic [XLEN-1:0] r_rf [0:31];
    logic [4:0]      w_rs, w_rt, w_rd, w_wb_addr;
    logic [XLEN-1:0] w_rs_val, w_rt_val, w_imm_sext, w_shamt, w_op2, w_alu_res;
    logic [XLEN-1:0] w_pc_plus4, w_wb_data, w_jump_tgt, w_branch_off;
    logic            w_zero, w_taken;

    mc_dp_sequencer u_seq (
        .i_clk              (clk),
        .i_rst_b            (rst_b),
        .i_halted           (halted),
        .i_imem_ready       (imem_ready),
        .i_dmem_ready       (dmem_ready),
        .i_mem_read         (mem_read),
        .i_mem_write        (mem_write),
        .i_reg_write_enable (reg_write_enable),
        .o_state            (w_state),
        .o_imem_req         (imem_req),
        .o_dmem_req         (dmem_req),
        .o_fetch_done       (w_fetch_done),
        .o_mem_done         (w_mem_done),
        .o_retire           (retire)
    );

    assign w_rs         = r_ir[25:21];
    assign w_rt         = r_ir[20:16];
    assign w_rd         = r_ir[15:11];
    assign w_rs_val     = (w_rs == 5'd0) ? '0 : r_rf[w_rs];
    assign w_rt_val     = (w_rt == 5'd0) ? '0 : r_rf[w_rt];
    assign w_imm_sext   = {{(XLEN-16){r_ir[15]}}, r_ir[15:0]};
    assign w_shamt      = XLEN'(r_ir[10:6]);
    assign w_op2        = does_shift_amount_need ? w_shamt : (alu_src ? w_imm_sext : r_b);
    assign w_alu_res    = alu_f(alu_operation, r_a, w_op2);
    assign w_zero       = (w_alu_res == '0);
    assign w_taken      = (branch & w_zero) | (branch_ne & ~w_zero);
    assign w_branch_off = {w_imm_sext[XLEN-3:0], 2'b00};
    assign w_jump_tgt   = {r_pc[XLEN-1:28], r_ir[25:0], 2'b00};
    // PC has already moved on by WB (jal), so the link value is rebuilt from the IR's own address
    assign w_pc_plus4   = r_inst_addr + XLEN'(4);
    assign w_wb_addr    = link ? REG_RA : (reg_dest ? w_rd : w_rt);
    assign w_wb_data    = reg_or_mem ? w_pc_plus4 : (mem_or_reg ? r_mdr : r_alu_out);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_pc         <= RESET_PC;
            r_ir         <= '0;
            r_inst_addr  <= RESET_PC;
            r_a          <= '0;
            r_b          <= '0;
            r_alu_out    <= '0;
            r_mdr        <= '0;
            r_misaligned <= 1'b0;
        end else begin
            if (w_fetch_done) begin
                r_ir        <= imem_rdata;
                r_inst_addr <= r_pc;
                r_pc        <= r_pc + XLEN'(4);
            end
            if (w_state == DECODE) begin
                r_a <= w_rs_val;
                r_b <= w_rt_val;
            end
            if (w_state == EXEC) begin
                r_alu_out <= w_alu_res;
                if (jump_register) r_pc <= r_a;
                else if (jump)     r_pc <= w_jump_tgt;
                else if (w_taken)  r_pc <= r_pc + w_branch_off;
            end
            if (w_mem_done) r_mdr <= dmem_rdata;
            if (dmem_req && (r_alu_out[1:0] != 2'b00)) r_misaligned <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if ((w_state == WB) && reg_write_enable && (w_wb_addr != 5'd0)) r_rf[w_wb_addr] <= w_wb_data;
    end

    assign inst       = r_ir;
    assign inst_addr  = r_inst_addr;
    assign imem_addr  = r_pc;
    assign dmem_addr  = {r_alu_out[XLEN-1:2], 2'b00};
    assign dmem_wdata = r_b;
    assign dmem_we    = dmem_req & mem_write;
    assign misaligned = r_misaligned;
    assign state      = w_state;

endmodule
